// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer
//   Drives a single DotProduct engine across every neuron of one MLP layer.
//   For each neuron it selects the weight row, holds the engine in reset for
//   RST_CYCLES cycles (that reset doubles as the engine's start), waits for
//   dp_endf, then writes the 32-bit float result into the layer output buffer.
//   The input vector A is held static by the caller for the whole layer.
//
// Ports
//   CLK        clock, rising edge
//   reset      asynchronous, active-high
//   start      begin a layer (taken in IDLE only)
//   abort      synchronous cancel back to IDLE (ignored in IDLE)
//   busy       high in every state except IDLE
//   done       one-cycle pulse at layer end (normal or timeout)
//   err        sticky watchdog-timeout flag, cleared by an accepted start
//   row_sel    weight row feeding DotProduct operand B
//   dp_rst     DotProduct reset/start, parked high while idle
//   dp_endf    DotProduct completion flag
//   dp_result  DotProduct result (IEEE-754 single)
//   wr_en      output buffer write strobe
//   wr_addr    output buffer address (neuron index), holds between strobes
//   wr_data    output buffer data, holds between strobes
module mlp_layer_sequencer #(
  parameter int N_NEURONS  = 10,
  parameter int IDX_W      = 4,
  parameter int RST_CYCLES = 2,
  parameter int TMO_W      = 12
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [IDX_W-1:0] row_sel,
  output logic             dp_rst,
  input  logic             dp_endf,
  input  logic [31:0]      dp_result,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_addr,
  output logic [31:0]      wr_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam int RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RST_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_NEURONS - 1);

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic [TMO_W-1:0]  wdog_q, wdog_d;
  logic              err_q, err_d;
  logic [IDX_W-1:0]  wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [TMO_W-1:0]  wdog_inc;

  assign wdog_inc = wdog_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rcnt_d    = rcnt_q;
    wdog_d    = wdog_q;
    err_d     = err_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (abort && (state_q != S_IDLE)) begin
      // Abort outranks completion and timeout: nothing is latched or flagged.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            idx_d   = '0;
            err_d   = 1'b0;
            rcnt_d  = '0;
            state_d = S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (rcnt_q == RCNT_LAST) begin
            wdog_d  = '0;
            state_d = S_RUN;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        S_RUN: begin
          wdog_d = wdog_inc;
          // wdog_q == 0 marks the first RUN cycle; an endf seen there is a
          // leftover from the previous neuron, so it is not trusted.
          if (dp_endf && (wdog_q != '0)) begin
            wr_addr_d = idx_q;
            wr_data_d = dp_result;
            state_d   = S_STORE;
          end else if (&wdog_inc) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
        S_STORE: begin
          if (idx_q == IDX_LAST) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            rcnt_d  = '0;
            state_d = S_CLEAR;
          end
        end
        S_FIN:   state_d = S_IDLE;
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      rcnt_q    <= '0;
      wdog_q    <= '0;
      err_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rcnt_q    <= rcnt_d;
      wdog_q    <= wdog_d;
      err_q     <= err_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset takes
  // effect in the same cycle.
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_FIN) || (state_q == S_ERR);
  assign dp_rst  = (state_q != S_RUN);
  assign wr_en   = (state_q == S_STORE);
  assign err     = err_q;
  assign row_sel = idx_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule
